// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg: shared constants and helpers for ram_port_arbiter (RAM_ARB_LOCK_EN adds the lock path).
// Revision 1.0
`default_nettype none

package ram_arb_pkg;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 16;

    // Bits needed to index n requesters; never less than 1.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    function automatic logic [15:0] onehot_enc(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

    function automatic logic [3:0] onehot_dec(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester handshake plus RAM port bundle (req_lock exists only with RAM_ARB_LOCK_EN).
// Revision 1.0
`default_nettype none

interface ram_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          ram_we;
    logic [ADDR_WIDTH-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0]         ram_din;
    logic [DATA_WIDTH-1:0]         ram_dout;
`ifdef RAM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]            req_lock;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_lock, ram_dout,
        input  req_ready, rsp_valid, rsp_data, ram_we, ram_addr, ram_din
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_lock, ram_dout,
        output req_ready, rsp_valid, rsp_data, ram_we, ram_addr, ram_din
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_dout,
        input  req_ready, rsp_valid, rsp_data, ram_we, ram_addr, ram_din
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_dout,
        output req_ready, rsp_valid, rsp_data, ram_we, ram_addr, ram_din
    );
`endif
endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter_rr_grant.sv
// rr_grant: combinational masked priority scan starting at ptr, wrapping modulo NUM_REQ.
// Revision 1.0
`default_nettype none

module rr_grant
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               any
);

    logic          w_found;
    logic [PW-1:0] w_pos;
    int            w_sum;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        w_sum   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
            w_pos = PW'(w_sum);
            if (!w_found && valid[w_pos] && mask[w_pos]) begin
                grant[w_pos] = 1'b1;
                w_found      = 1'b1;
            end
        end
        any = w_found;
        idx = PW'(onehot_dec(16'(grant)));
    end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of one RAM port with 1-cycle tagged read return (RAM_ARB_LOCK_EN adds locking).
// Revision 1.0
`default_nettype none

module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rstn,
    ram_port_arbiter_if.slave   bus
);

    localparam int            PW     = clog2(NUM_REQ);
    localparam logic [PW-1:0] c_last = PW'(NUM_REQ - 1);

    generate
        if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
            $error("ram_port_arbiter: NUM_REQ out of range");
        end
    endgenerate

    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_sel;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_mask;
    logic [PW-1:0]      w_idx;
    logic [PW-1:0]      w_sel;
    logic               w_any;
    logic               w_accept;
    logic               w_lock_beat;

`ifdef RAM_ARB_LOCK_EN
    logic          r_locked;
    logic [PW-1:0] r_owner;

    assign w_mask      = r_locked ? NUM_REQ'(onehot_enc(4'(r_owner))) : '1;
    assign w_lock_beat = bus.req_lock[w_idx];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_locked <= 1'b0;
            r_owner  <= '0;
        end else if (w_accept) begin
            r_locked <= w_lock_beat;
            r_owner  <= w_idx;
        end
    end
`else
    assign w_mask      = '1;
    assign w_lock_beat = 1'b0;
`endif

    rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
        .valid (bus.req_valid),
        .mask  (w_mask),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    assign w_accept      = w_any & rstn;
    assign bus.req_ready = rstn ? w_grant : '0;

    // Idle cycles keep the last granted requester on the address/data mux.
    assign w_sel         = w_any ? w_idx : r_sel;
    assign bus.ram_addr  = bus.req_addr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.ram_din   = bus.req_wdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.ram_we    = w_accept & bus.req_we[w_idx];

    // Gating with rstn drops a read whose response would land in a reset cycle.
    assign bus.rsp_valid = rstn ? r_rsp_valid : '0;
    assign bus.rsp_data  = bus.ram_dout;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= '0;
        end else if (w_accept) begin
            r_sel       <= w_idx;
            r_rsp_valid <= bus.req_we[w_idx] ? '0 : NUM_REQ'(onehot_enc(4'(w_idx)));
            if (!w_lock_beat) begin
                r_ptr <= (w_idx == c_last) ? '0 : w_idx + 1'b1;
            end
        end else begin
            r_rsp_valid <= '0;
        end
    end

endmodule

`default_nettype wire
